// File: rtl/icache_direct_pkg.sv
// Shared constants and bus types for the direct-mapped instruction cache.
// Define ICACHE_STAT_EN to add the hit/miss statistics counters.
package icache_direct_pkg;

  typedef logic [31:0] InstBus;
  typedef logic [31:0] InstAddrBus;

  localparam InstBus ZeroWord     = 32'h0000_0000;
  localparam logic   RstEnable    = 1'b0;
  localparam logic   WriteEnable  = 1'b1;
  localparam logic   WriteDisable = 1'b0;
  localparam logic   LTrue        = 1'b1;
  localparam logic   LFalse       = 1'b0;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-stage <-> icache lookup/fill interface.
// With ICACHE_STAT_EN the statistics outputs are carried here too.
interface icache_direct_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  req_i;
  logic [ADDR_WIDTH-1:0] raddr_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] waddr_i;
  logic [31:0]           wdata_i;
  logic                  flush_i;
  logic [31:0]           inst_o;
  logic                  hit_o;
`ifdef ICACHE_STAT_EN
  logic [31:0]           stat_hit_o;
  logic [31:0]           stat_miss_o;

  modport master (
    output req_i, raddr_i, we_i,
    output waddr_i, wdata_i, flush_i,
    input  inst_o, hit_o,
    input  stat_hit_o, stat_miss_o
  );

  modport slave (
    input  req_i, raddr_i, we_i,
    input  waddr_i, wdata_i, flush_i,
    output inst_o, hit_o,
    output stat_hit_o, stat_miss_o
  );
`else
  modport master (
    output req_i, raddr_i, we_i,
    output waddr_i, wdata_i, flush_i,
    input  inst_o, hit_o
  );

  modport slave (
    input  req_i, raddr_i, we_i,
    input  waddr_i, wdata_i, flush_i,
    output inst_o, hit_o
  );
`endif

endinterface

// File: rtl/icache_tag_ram.sv
// Tag + valid store for the direct-mapped icache.
// Valid bits clear on reset and flush; tags are never reset.
module icache_tag_ram #(
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] widx,
  input  logic [TAG_WIDTH-1:0]   wtag,
  input  logic [INDEX_WIDTH-1:0] ridx,
  input  logic [TAG_WIDTH-1:0]   rtag,
  output logic                   match
);
  import icache_direct_pkg::*;

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] tags [LINES];
  logic [LINES-1:0]     valid;

  // Flush beats a same-cycle fill so the line stays invalid
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (we == WriteEnable) begin
      valid[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we == WriteEnable) begin
      tags[widx] <= wtag;
    end
  end

  assign match = valid[ridx] && (tags[ridx] == rtag);

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped one-word-line instruction cache, 1-cycle lookup.
// Define ICACHE_STAT_EN to add stat_hit_o / stat_miss_o counters.
module icache_direct #(
  parameter int INDEX_WIDTH = 7,
  parameter int ADDR_WIDTH  = 32
) (
  input logic            clk,
  input logic            rst,
  icache_direct_if.slave bus
);
  import icache_direct_pkg::*;

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;

  function automatic logic [INDEX_WIDTH-1:0] idx_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[INDEX_WIDTH+1:2];
  endfunction

  function automatic logic [TAG_WIDTH-1:0] tag_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[ADDR_WIDTH-1:INDEX_WIDTH+2];
  endfunction

  logic [INDEX_WIDTH-1:0] ridx;
  logic [INDEX_WIDTH-1:0] widx;
  logic [TAG_WIDTH-1:0]   rtag;
  logic [TAG_WIDTH-1:0]   wtag;
  logic                   match;
  logic                   hit_d;
  InstBus                 inst_d;
  InstBus                 inst_q;
  logic                   hit_q;
  InstBus                 data [LINES];
  logic                   unused_ok;

  assign ridx = idx_of(bus.raddr_i);
  assign widx = idx_of(bus.waddr_i);
  assign rtag = tag_of(bus.raddr_i);
  assign wtag = tag_of(bus.waddr_i);

  assign unused_ok = ^{bus.raddr_i[1:0], bus.waddr_i[1:0]};

  icache_tag_ram #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_tag_ram (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.flush_i),
    .we    (bus.we_i),
    .widx  (widx),
    .wtag  (wtag),
    .ridx  (ridx),
    .rtag  (rtag),
    .match (match)
  );

  always_ff @(posedge clk) begin
    if (bus.we_i == WriteEnable && !bus.flush_i && rst != RstEnable) begin
      data[widx] <= bus.wdata_i;
    end
  end

  // A fill to the looked-up index wins over the stored line
  always_comb begin
    hit_d  = LFalse;
    inst_d = ZeroWord;
    if (bus.req_i && !bus.flush_i) begin
      if (bus.we_i == WriteEnable && widx == ridx) begin
        if (wtag == rtag) begin
          hit_d  = LTrue;
          inst_d = bus.wdata_i;
        end
      end else if (match) begin
        hit_d  = LTrue;
        inst_d = data[ridx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      inst_q <= ZeroWord;
      hit_q  <= LFalse;
    end else begin
      inst_q <= inst_d;
      hit_q  <= hit_d;
    end
  end

  assign bus.inst_o = inst_q;
  assign bus.hit_o  = hit_q;

`ifdef ICACHE_STAT_EN
  logic [31:0] stat_hit_q;
  logic [31:0] stat_miss_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else if (bus.req_i) begin
      if (hit_d) stat_hit_q  <= stat_hit_q + 32'd1;
      else       stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign bus.stat_hit_o  = stat_hit_q;
  assign bus.stat_miss_o = stat_miss_q;
`endif

endmodule
